// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and runs the fetch/execute loop.
// The loop is fetch from instruction memory, hand the word to execute, then
// step or branch the pc when execute retires it.
//
// Optional feature macro: PC_SEQ_RETIRE_CNT_EN adds a 32-bit retire_count output.
// Without it the port and the counter are absent and nothing else changes.
//
// Handshakes:
//   imem_req/imem_ack: imem_req rises in the first FETCH cycle.
//     imem_req and imem_addr then hold steady until a cycle with imem_ack=1.
//     In that cycle imem_data is captured and imem_req drops on the next edge.
//     imem_ack outside FETCH is ignored.
//   instr_valid/exec_done: instr_valid pulses for one cycle when instr is new.
//     Execute may take any number of cycles to retire the instruction.
//     It signals retirement with a one-cycle exec_done.
//     branch_take/branch_target are sampled only in that cycle.
//
// state_dbg exposes the FSM state: IDLE=0 FETCH=1 EXEC=2 HALT=3 FAULT=4.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH      = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned         PC_STEP       = 1,
  parameter int unsigned         FETCH_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                halt_req,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [15:0]         instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                branch_take,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                fault,
`ifdef PC_SEQ_RETIRE_CNT_EN
  output logic [31:0]         retire_count,
`endif
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);
  localparam logic [31:0]         TO_LAST = FETCH_TIMEOUT - 1;
  localparam bit                  TO_EN = (FETCH_TIMEOUT != 0);

  state_t      state;
  logic        halt_pending;
  logic [31:0] to_cnt;

  // pc is a register, so the fetch address is registered as well.
  // The fetch address is stable for the whole request.
  assign imem_addr = pc;
  assign state_dbg = state;

  // Sequencer FSM: all state and outputs update here on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      instr        <= 16'h0000;
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      to_cnt       <= '0;
      halt_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A halt request beats run, so a core can be parked before it ever fetches.
          if (halt_req) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            to_cnt   <= '0;
          end
        end

        S_FETCH: begin
          // A halt request here is remembered until the in-flight instruction retires.
          if (halt_req) begin
            halt_pending <= 1'b1;
          end
          if (imem_ack) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_EXEC;
          end else begin
            to_cnt <= to_cnt + 32'd1;
            // The timeout fires on the edge that ends the FETCH_TIMEOUT-th unanswered cycle.
            if (TO_EN && (to_cnt == TO_LAST)) begin
              imem_req <= 1'b0;
              fault    <= 1'b1;
              state    <= S_FAULT;
            end
          end
        end

        S_EXEC: begin
          instr_valid <= 1'b0;
          if (halt_req) begin
            halt_pending <= 1'b1;
          end
          if (exec_done) begin
            if (branch_take) begin
              pc <= branch_target;
            end else begin
              pc <= pc + STEP;
            end
            if (halt_pending || halt_req) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              // The request goes out on the next cycle with the updated pc.
              state    <= S_FETCH;
              imem_req <= 1'b1;
              to_cnt   <= '0;
            end
          end
        end

        S_HALT: begin
          if (run && !halt_req) begin
            state        <= S_FETCH;
            halted       <= 1'b0;
            halt_pending <= 1'b0;
            imem_req     <= 1'b1;
            to_cnt       <= '0;
          end
        end

        S_FAULT: begin
          // Sticky: only rst leaves this state.
          imem_req <= 1'b0;
          fault    <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_RETIRE_CNT_EN
  // Retire counter: counts every instruction retired in EXEC and wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= 32'd0;
    end else if ((state == S_EXEC) && exec_done) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule
